// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan_module: control, selects, mask and flattened channel data in; selected sample out.
interface mux_scan_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3
);
  logic                  CSn;
  logic                  MODE;
  logic [SEL_W-1:0]      A;
  logic [CH-1:0]         MASK;
  logic [CH*WIDTH-1:0]   D;
  logic [WIDTH-1:0]      Y;
  logic [SEL_W-1:0]      CH_ID;
  logic                  VALID;

  modport master (output CSn, MODE, A, MASK, D, input Y, CH_ID, VALID);
  modport slave  (input CSn, MODE, A, MASK, D, output Y, CH_ID, VALID);
endinterface

// File: rtl/mux_scan_module.sv
// Registered N-channel selector with manual select and masked auto-scan with programmable dwell.
// Optional MUX_SCAN_HOLD_LAST_EN: Y holds its last value in IDLE and on masked/out-of-range manual selects.
module mux_scan_module #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  mux_scan_if.slave   bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state_q, state_nx;
  logic [SEL_W-1:0] ptr_q, ptr_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [WIDTH-1:0] y_q, y_nx, y_off;
  logic [SEL_W-1:0] ch_id_q, ch_id_nx;
  logic             valid_q, valid_nx;
  logic [SEL_W-1:0] sel;
  logic             adv;
  logic             man_ok;

  // First enabled channel circularly from p: inclusive of p when incl=1, strictly after p otherwise.
  // Scanning offsets from far to near leaves the nearest enabled channel as the result.
  function automatic logic [SEL_W-1:0] find_en(input logic [CH-1:0] m,
                                               input logic [SEL_W-1:0] p,
                                               input logic incl);
    logic [SEL_W-1:0] r;
    int idx;
    r = p;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(p) + k - int'(incl)) % CH;
      if (m[idx]) r = SEL_W'(idx);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++)
      if (s == SEL_W'(i)) r = d[i*WIDTH +: WIDTH];
    return r;
  endfunction

  // Out-of-range indices read as disabled.
  function automatic logic mask_at(input logic [CH-1:0] m, input logic [SEL_W-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < CH; i++)
      if (s == SEL_W'(i)) r = m[i];
    return r;
  endfunction

`ifdef MUX_SCAN_HOLD_LAST_EN
  assign y_off = y_q;
`else
  assign y_off = '0;
`endif

  assign man_ok = mask_at(bus.MASK, bus.A);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ch_id_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      ptr_q   <= ptr_nx;
      cnt_q   <= cnt_nx;
      y_q     <= y_nx;
      ch_id_q <= ch_id_nx;
      valid_q <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    y_nx     = y_q;
    ch_id_nx = ch_id_q;
    valid_nx = 1'b0;
    sel      = ptr_q;
    adv      = 1'b0;
    if (bus.CSn) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      y_nx     = y_off;
    end else if (!bus.MODE) begin
      state_nx = MANUAL;
      cnt_nx   = '0;
      ch_id_nx = bus.A;
      if (man_ok) begin
        y_nx     = pick(bus.D, bus.A);
        valid_nx = (state_q != MANUAL) || (bus.A != ch_id_q);
      end else begin
        y_nx     = y_off;
      end
    end else begin
      state_nx = SCAN;
      if (bus.MASK == '0) begin
        y_nx     = '0;
        ch_id_nx = ptr_q;
      end else begin
        // Entry re-anchors on ptr itself; a dropped channel or expired dwell moves strictly past it.
        if (state_q != SCAN) begin
          sel = find_en(bus.MASK, ptr_q, 1'b1);
          adv = 1'b1;
        end else if (!mask_at(bus.MASK, ptr_q) || cnt_q == CNT_LAST) begin
          sel = find_en(bus.MASK, ptr_q, 1'b0);
          adv = 1'b1;
        end
        ptr_nx   = sel;
        ch_id_nx = sel;
        y_nx     = pick(bus.D, sel);
        valid_nx = adv;
        cnt_nx   = adv ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.Y     = y_q;
  assign bus.CH_ID = ch_id_q;
  assign bus.VALID = valid_q;

endmodule

// File: tb/tb_mux_scan_module.sv
// Scoreboard bench for mux_scan_module: a DWELL=4 instance for manual/scan/mask/abort and a DWELL=1 instance.
module tb_mux_scan_module;

`ifdef MUX_SCAN_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] id;
    logic       v;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t sbq1[$];

  mux_scan_if #(.WIDTH(8), .CH(8), .SEL_W(3)) if4 ();
  mux_scan_if #(.WIDTH(8), .CH(8), .SEL_W(3)) if1 ();

  mux_scan_module #(.WIDTH(8), .CH(8), .SEL_W(3), .DWELL(4)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .bus(if4.slave));
  mux_scan_module #(.WIDTH(8), .CH(8), .SEL_W(3), .DWELL(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .bus(if1.slave));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [7:0] y, input int id, input logic v);
    exp_t e;
    e.y = y; e.id = 3'(id); e.v = v;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t o;
    #3 RSTn = 1'b0;
    #1;
    o = {if4.Y, if4.CH_ID, if4.VALID};
    checks++;
    if (o !== 12'h0) begin
      failures++;
      $display("FAIL reset_dut4: got Y=%h CH_ID=%0d VALID=%b, expected all zero", o.y, o.id, o.v);
    end
    o = {if1.Y, if1.CH_ID, if1.VALID};
    checks++;
    if (o !== 12'h0) begin
      failures++;
      $display("FAIL reset_dut1: got Y=%h CH_ID=%0d VALID=%b, expected all zero", o.y, o.id, o.v);
    end
    repeat (2) tick();
    RSTn = 1'b1;
    sbq.push_back(mk(8'h00, 0, 1'b0));
    tick();
    o = {if4.Y, if4.CH_ID, if4.VALID};
    checks++;
    if (o !== sbq.pop_front()) begin
      failures++;
      $display("FAIL reset_idle: got Y=%h CH_ID=%0d VALID=%b, expected Y=00 CH_ID=0 VALID=0", o.y, o.id, o.v);
    end
  endtask

  task automatic test_manual();
    exp_t e, o;
    int   a_seq[6]  = '{5, 5, 2, 2, 5, 5};
    logic [7:0] m_seq[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hFF};
    if4.CSn = 1'b0;
    if4.MODE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if4.A = 3'(a_seq[c]);
      if4.MASK = m_seq[c];
      case (c)
        0: sbq.push_back(mk(8'h15, 5, 1'b1));
        1: sbq.push_back(mk(8'h15, 5, 1'b0));
        2: sbq.push_back(mk(8'h12, 2, 1'b1));
        3: sbq.push_back(mk(8'h12, 2, 1'b0));
        4: sbq.push_back(mk(HOLD ? 8'h12 : 8'h00, 5, 1'b0));
        default: sbq.push_back(mk(8'h15, 5, 1'b0));
      endcase
      tick();
      e = sbq.pop_front();
      o = {if4.Y, if4.CH_ID, if4.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL manual[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e, o;
    int seq[5] = '{0, 2, 5, 7, 0};
    if4.MASK = 8'hA5;
    if4.MODE = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sbq.push_back(mk(8'h10 + 8'(seq[c/4]), seq[c/4], (c % 4) == 0));
      tick();
      e = sbq.pop_front();
      o = {if4.Y, if4.CH_ID, if4.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL scan[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  task automatic test_mask_edge();
    exp_t e, o;
    for (int c = 0; c < 20; c++) begin
      if (c < 12) begin
        if4.MASK = 8'h08;
        sbq.push_back(mk(8'h13, 3, (c % 4) == 0));
      end else if (c < 15) begin
        if4.MASK = 8'h00;
        sbq.push_back(mk(8'h00, 3, 1'b0));
      end else if (c < 17) begin
        if4.MASK = 8'hA5;
        sbq.push_back(mk(8'h15, 5, c == 15));
      end else begin
        if4.MASK = 8'h85;
        sbq.push_back(mk(8'h17, 7, c == 17));
      end
      tick();
      e = sbq.pop_front();
      o = {if4.Y, if4.CH_ID, if4.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mask_edge[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  task automatic test_csn_abort();
    exp_t e, o;
    for (int c = 0; c < 7; c++) begin
      if4.CSn = (c < 2);
      if (c < 2)       sbq.push_back(mk(HOLD ? 8'h17 : 8'h00, 7, 1'b0));
      else if (c < 6)  sbq.push_back(mk(8'h17, 7, c == 2));
      else             sbq.push_back(mk(8'h10, 0, 1'b1));
      tick();
      e = sbq.pop_front();
      o = {if4.Y, if4.CH_ID, if4.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL csn_abort[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  task automatic test_dwell1();
    exp_t e, o;
    if1.MASK = 8'hFF;
    if1.MODE = 1'b1;
    if1.CSn = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        sbq1.push_back(mk(8'h10 + 8'(c % 8), c % 8, 1'b1));
      end else begin
        if1.MODE = 1'b0;
        if1.A = 3'd6;
        sbq1.push_back(mk(8'h16, 6, c == 10));
      end
      tick();
      e = sbq1.pop_front();
      o = {if1.Y, if1.CH_ID, if1.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL dwell1[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  task automatic test_reset_async();
    exp_t e, o;
    if4.MASK = 8'h80;
    tick();
    #3 RSTn = 1'b0;
    #1;
    o = {if4.Y, if4.CH_ID, if4.VALID};
    checks++;
    if (o !== 12'h0) begin
      failures++;
      $display("FAIL async_reset: got Y=%h CH_ID=%0d VALID=%b, expected all zero", o.y, o.id, o.v);
    end
    if4.CSn = 1'b1;
    tick();
    RSTn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        sbq.push_back(mk(8'h00, 0, 1'b0));
      end else begin
        if4.CSn = 1'b0;
        if4.MODE = 1'b1;
        if4.MASK = 8'hFF;
        sbq.push_back(mk(8'h10, 0, 1'b1));
      end
      tick();
      e = sbq.pop_front();
      o = {if4.Y, if4.CH_ID, if4.VALID};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset[%0d]: got Y=%h CH_ID=%0d VALID=%b, expected Y=%h CH_ID=%0d VALID=%b",
                 c, o.y, o.id, o.v, e.y, e.id, e.v);
      end
    end
  endtask

  initial begin
    RSTn = 1'b1;
    if4.CSn = 1'b1; if4.MODE = 1'b0; if4.A = '0; if4.MASK = 8'hFF;
    if1.CSn = 1'b1; if1.MODE = 1'b0; if1.A = '0; if1.MASK = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if4.D[i*8 +: 8] = 8'h10 + 8'(i);
      if1.D[i*8 +: 8] = 8'h10 + 8'(i);
    end
    test_reset();
    test_manual();
    test_scan();
    test_mask_edge();
    test_csn_abort();
    test_dwell1();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_module.md
Name: mux_scan_module

Overview:
- Parametrised, registered N-channel data selector, successor to the fixed 8:1 combinational mux.
- Adds a registered output, per-channel enable mask and an auto-scan mode that steps through enabled channels with a programmable dwell time.
- Used to time-multiplex several data sources (e.g. display digits, sensor words) onto one bus, with a VALID strobe marking each new channel sample.

Parameters:
- WIDTH, 8, data width per channel
- CH, 8, number of input channels (2..16)
- SEL_W, 3, select/pointer width; must satisfy 2**SEL_W >= CH
- DWELL, 4, clock cycles each channel is held in scan mode (>=1)

Ports:
- CLK  input  1  system clock, rising edge
- RSTn  input  1  asynchronous active-low reset
- CSn  input  1  active-low chip select; high forces idle
- MODE  input  1  0 = manual select via A, 1 = auto scan
- A  input  SEL_W  manual channel select
- MASK  input  CH  per-channel enable; bit i = 1 enables channel i
- D  input  CH*WIDTH  flattened channel data; channel i = D[i*WIDTH +: WIDTH]
- Y  output  WIDTH  registered selected data
- CH_ID  output  SEL_W  channel index currently driven on Y
- VALID  output  1  one-cycle strobe: new channel sample on Y

Behaviour:
- Reset (RSTn=0, async):
  - Y=0, CH_ID=0, VALID=0.
  - Internal pointer ptr=0, dwell counter cnt=0, state IDLE.
- States: IDLE, MANUAL, SCAN. All state and outputs update on the rising CLK edge.
- IDLE:
  - Entered whenever CSn=1 (from any state, next edge). Y=0, VALID=0, cnt cleared; ptr and CH_ID retain their values.
  - CSn=0 with MODE=0 -> MANUAL; CSn=0 with MODE=1 -> SCAN.
- MANUAL:
  - Each cycle: Y <= D[A], CH_ID <= A. Latency 1 cycle from A/D to Y.
  - VALID=1 on the first MANUAL cycle and on any cycle where A differs from the previous registered CH_ID; otherwise 0.
  - A >= CH or MASK[A]=0: Y <= 0, VALID=0, CH_ID <= A.
  - MODE=1 -> SCAN next edge.
- SCAN:
  - On entry, cnt=0 and ptr = first enabled channel at or after current ptr, searching circularly.
  - Each cycle Y <= D[ptr] (live data) and CH_ID <= ptr.
  - cnt counts 0..DWELL-1. When cnt==DWELL-1, ptr <= next enabled channel strictly after ptr, circularly (CH-1 wraps to 0), and cnt <= 0.
  - If ptr is the only enabled channel, it stays on ptr.
  - VALID=1 on the cycle Y first carries a newly selected channel (entry, or each dwell restart), else 0. DWELL=1 gives VALID=1 every cycle.
  - If MASK[ptr] drops mid-dwell: advance to the next enabled channel on the next edge, cnt <= 0, VALID pulses.
  - MASK all zero: Y=0, VALID=0, ptr and cnt hold.
  - MODE=0 -> MANUAL next edge; cnt cleared.
- Simultaneous events: CSn=1 has priority over MODE changes and dwell expiry.
- Next-enabled search is combinational, single cycle; no multicycle paths.

Optional Feature:
- Macro: MUX_SCAN_HOLD_LAST_EN.
- Defined: in IDLE, and for masked or out-of-range manual selects, Y holds its last value instead of 0. VALID behaviour is unchanged.
- Undefined: Y forced to 0 as above.

Test Plan:
- Reset check: WIDTH=8, CH=8. Assert RSTn=0 mid-scan -> Y=0, CH_ID=0, VALID=0 immediately, without waiting for CLK. Release -> IDLE.
- Manual select: CSn=0, MODE=0, D[i]=8'h10+i, A=5 -> Y=8'h15 one cycle later with VALID pulse. Hold A=5 -> VALID=0. A=5->2 -> Y=8'h12 with one VALID pulse.
- Scan with mask: MODE=1, DWELL=4, MASK=8'b1010_0101 -> CH_ID sequence 0,2,5,7,0..., each held 4 cycles. VALID on the first cycle of each dwell. Wrap 7->0 verified.
- Mask edge cases: MASK=8'b0000_1000 -> CH_ID stays 3, VALID every 4 cycles. MASK=0 -> Y=0, VALID=0. Clear MASK[ptr] mid-dwell -> jump next cycle.
- CSn abort: CSn=1 at cnt=2 -> Y=0 next edge (held value with MUX_SCAN_HOLD_LAST_EN). CSn=0 -> resume at same ptr with cnt=0 and a VALID pulse.
- DWELL=1 and mode switch: scan MASK=8'hFF -> CH_ID increments every cycle, VALID constantly 1. Switch MODE=0 with A=6 -> Y=D[6] next cycle.
